// File: rtl/riscv_multicycle_controller_if.sv
// Control bus between the multicycle RV32I controller and its datapath.
// The controller side uses the master modport and the datapath side uses the slave modport.
interface riscv_multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] ImmSrc;
  logic       RegWrite;

  modport master (
    input  op, funct3, funct7b5, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegWrite
  );

  modport slave (
    output op, funct3, funct7b5, Zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegWrite
  );
endinterface

// File: rtl/riscv_multicycle_controller.sv
// Moore-FSM control unit for the multicycle RV32I core with ALU and immediate decoders.
// Optional macro BNE_EN: branch state also implements bne (funct3=001) by inverting Zero.
module riscv_multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  riscv_multicycle_controller_if.master ctrl,
  output logic [STATE_W-1:0]        State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t     state, next_state;
  logic       pc_update, branch, branch_taken;
  logic       adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [2:0] alu_control;
  logic [1:0] imm_src;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = FETCH;
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    case (state)
      FETCH: begin
        next_state = DECODE;
        ir_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_update  = 1'b1;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        // Unknown opcodes fall back to FETCH with no strobe, skipping the instruction
        case (ctrl.op)
          OP_LOAD, OP_STORE: next_state = MEMADR;
          OP_RTYPE:          next_state = EXECR;
          OP_ITYPE:          next_state = EXECI;
          OP_JAL:            next_state = JAL;
          OP_BRANCH:         next_state = BEQ;
          default:           next_state = FETCH;
        endcase
      end
      MEMADR: begin
        next_state = (ctrl.op == OP_LOAD) ? MEMREAD : MEMWRITE;
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
      end
      MEMREAD: begin
        next_state = MEMWB;
        adr_src    = 1'b1;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      EXECR: begin
        next_state = ALUWB;
        alu_src_a  = 2'b10;
        alu_op     = 2'b10;
      end
      EXECI: begin
        next_state = ALUWB;
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        alu_op     = 2'b10;
      end
      ALUWB: reg_write = 1'b1;
      JAL: begin
        next_state = ALUWB;
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_update  = 1'b1;
      end
      BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      default: next_state = FETCH;
    endcase
  end

  always_comb begin
    alu_control = 3'b000;
    case (alu_op)
      2'b01: alu_control = 3'b001;
      2'b10: begin
        // Only R-type (op[5]=1) may turn funct3=000 into sub, so addi stays add
        case (ctrl.funct3)
          3'b000:  alu_control = (ctrl.op[5] & ctrl.funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

  always_comb begin
    imm_src = 2'b00;
    case (ctrl.op)
      OP_STORE:  imm_src = 2'b01;
      OP_BRANCH: imm_src = 2'b10;
      OP_JAL:    imm_src = 2'b11;
      default:   imm_src = 2'b00;
    endcase
  end

`ifdef BNE_EN
  assign branch_taken = (ctrl.funct3 == 3'b001) ? ~ctrl.Zero : ctrl.Zero;
`else
  assign branch_taken = ctrl.Zero;
`endif

  // Strobes are gated by reset so nothing is written while the core is held
  assign ctrl.PCWrite    = ~reset & (pc_update | (branch & branch_taken));
  assign ctrl.IRWrite    = ~reset & ir_write;
  assign ctrl.MemWrite   = ~reset & mem_write;
  assign ctrl.RegWrite   = ~reset & reg_write;
  assign ctrl.AdrSrc     = adr_src;
  assign ctrl.ResultSrc  = result_src;
  assign ctrl.ALUSrcA    = alu_src_a;
  assign ctrl.ALUSrcB    = alu_src_b;
  assign ctrl.ALUControl = alu_control;
  assign ctrl.ImmSrc     = imm_src;
  assign State           = STATE_W'(state);

endmodule

// File: tb/tb_riscv_multicycle_controller.sv
// Scoreboard bench for riscv_multicycle_controller: an instruction-level model pushes the
// expected per-cycle control word, and a negedge monitor pops and compares it to the DUT.
module tb_riscv_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] State;

  riscv_multicycle_controller_if bus ();

  riscv_multicycle_controller #(.STATE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (bus),
    .State (State)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       irw;
    logic [1:0] rs;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [2:0] aluc;
    logic [1:0] imm;
    logic       rw;
  } rec_t;

  rec_t  expq[$];
  string nameq[$];
  int    errors = 0;
  int    checks = 0;

  // Number of clocks an instruction takes, from its opcode
  function automatic int path_len(input logic [6:0] op);
    case (op)
      OP_LW:                   return 5;
      OP_SW, OP_R, OP_I, OP_JAL: return 4;
      OP_BR:                   return 3;
      default:                 return 2;
    endcase
  endfunction

  function automatic logic [3:0] path_state(input logic [6:0] op, input int idx);
    logic [3:0] p [5];
    p = '{4'd0, 4'd1, 4'd0, 4'd0, 4'd0};
    case (op)
      OP_LW:  p = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
      OP_SW:  p = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
      OP_R:   p = '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0};
      OP_I:   p = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd0};
      OP_JAL: p = '{4'd0, 4'd1, 4'd9, 4'd8, 4'd0};
      OP_BR:  p = '{4'd0, 4'd1, 4'd10, 4'd0, 4'd0};
      default: ;
    endcase
    return p[idx];
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] op);
    case (op)
      OP_SW:   return 2'b01;
      OP_BR:   return 2'b10;
      OP_JAL:  return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // Arithmetic the instruction asks for in its execute step
  function automatic logic [2:0] exec_alu(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (op == OP_R && f7) ? ALU_SUB : ALU_ADD;
      3'b010:  return ALU_SLT;
      3'b110:  return ALU_OR;
      3'b111:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic taken(input logic [2:0] f3, input logic z);
`ifdef BNE_EN
    if (f3 == 3'b001) return !z;
`endif
    return z;
  endfunction

  function automatic rec_t expect_rec(input logic [3:0] st, input logic [6:0] op, input logic [2:0] f3,
                                      input logic f7, input logic z, input logic rst);
    rec_t r;
    r      = '0;
    r.st   = st;
    r.imm  = imm_of(op);
    r.aluc = ALU_ADD;
    case (st)
      4'd0:  begin r.irw = 1; r.sb = 2'b10; r.rs = 2'b10; r.pcw = 1; end
      4'd1:  begin r.sa = 2'b01; r.sb = 2'b01; end
      4'd2:  begin r.sa = 2'b10; r.sb = 2'b01; end
      4'd3:  r.adr = 1;
      4'd4:  begin r.rs = 2'b01; r.rw = 1; end
      4'd5:  begin r.adr = 1; r.mw = 1; end
      4'd6:  begin r.sa = 2'b10; r.sb = 2'b00; r.aluc = exec_alu(op, f3, f7); end
      4'd7:  begin r.sa = 2'b10; r.sb = 2'b01; r.aluc = exec_alu(op, f3, f7); end
      4'd8:  r.rw = 1;
      4'd9:  begin r.sa = 2'b01; r.sb = 2'b10; r.pcw = 1; end
      4'd10: begin r.sa = 2'b10; r.aluc = ALU_SUB; r.pcw = taken(f3, z); end
      default: ;
    endcase
    if (rst) begin
      r.pcw = 0; r.irw = 0; r.mw = 0; r.rw = 0;
    end
    return r;
  endfunction

  task automatic checkOutput();
    rec_t  e;
    rec_t  a;
    string n;
    e = expq.pop_front();
    n = nameq.pop_front();
    a.st   = State;
    a.pcw  = bus.PCWrite;
    a.adr  = bus.AdrSrc;
    a.mw   = bus.MemWrite;
    a.irw  = bus.IRWrite;
    a.rs   = bus.ResultSrc;
    a.sa   = bus.ALUSrcA;
    a.sb   = bus.ALUSrcB;
    a.aluc = bus.ALUControl;
    a.imm  = bus.ImmSrc;
    a.rw   = bus.RegWrite;
    checks++;
    if (a !== e) begin
      errors++;
      $display("[TB] FAIL %s state=%0d: actual st=%0d pcw=%b adr=%b mw=%b irw=%b rs=%b sa=%b sb=%b alu=%b imm=%b rw=%b required st=%0d pcw=%b adr=%b mw=%b irw=%b rs=%b sa=%b sb=%b alu=%b imm=%b rw=%b",
               n, e.st, a.st, a.pcw, a.adr, a.mw, a.irw, a.rs, a.sa, a.sb, a.aluc, a.imm, a.rw,
               e.st, e.pcw, e.adr, e.mw, e.irw, e.rs, e.sa, e.sb, e.aluc, e.imm, e.rw);
    end
  endtask

  // Monitor: the DUT presents a new control word every cycle
  always @(negedge clk) begin
    if (expq.size() > 0) checkOutput();
  end

  // Runs an instruction for min(limit, latency) cycles, entered just after a rising edge
  task automatic applyStimulus(input string name, input logic [6:0] op, input logic [2:0] f3,
                               input logic f7, input logic z, input bit zrand, input int limit);
    int n;
    n = path_len(op);
    if (limit < n) n = limit;
    bus.op       = op;
    bus.funct3   = f3;
    bus.funct7b5 = f7;
    for (int c = 0; c < n; c++) begin
      bus.Zero = zrand ? 1'($urandom_range(0, 1)) : z;
      expq.push_back(expect_rec(path_state(op, c), op, f3, f7, bus.Zero, 1'b0));
      nameq.push_back(name);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic resetCycles(input int n);
    reset = 1'b1;
    for (int c = 0; c < n; c++) begin
      expq.push_back(expect_rec(4'd0, bus.op, bus.funct3, bus.funct7b5, bus.Zero, 1'b1));
      nameq.push_back("reset");
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  initial begin
    logic [6:0] rop;
    int         pick;
    bus.op       = OP_LW;
    bus.funct3   = 3'b000;
    bus.funct7b5 = 1'b0;
    bus.Zero     = 1'b0;
    @(posedge clk);
    #1;
    resetCycles(2);

    applyStimulus("lw",       OP_LW,  3'b010, 1'b0, 1'b0, 1'b1, 99);
    applyStimulus("sw",       OP_SW,  3'b010, 1'b0, 1'b0, 1'b1, 99);
    applyStimulus("sub",      OP_R,   3'b000, 1'b1, 1'b0, 1'b1, 99);
    applyStimulus("addi_f7",  OP_I,   3'b000, 1'b1, 1'b0, 1'b1, 99);
    applyStimulus("slt",      OP_R,   3'b010, 1'b0, 1'b0, 1'b1, 99);
    applyStimulus("beq_z1",   OP_BR,  3'b000, 1'b0, 1'b1, 1'b0, 99);
    applyStimulus("beq_z0",   OP_BR,  3'b000, 1'b0, 1'b0, 1'b0, 99);
    applyStimulus("jal",      OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1, 99);
    applyStimulus("illegal",  7'b1111111, 3'b000, 1'b0, 1'b1, 1'b0, 99);
    applyStimulus("bne_z0",   OP_BR,  3'b001, 1'b0, 1'b0, 1'b0, 99);
    applyStimulus("bne_z1",   OP_BR,  3'b001, 1'b0, 1'b1, 1'b0, 99);
    applyStimulus("lw_abort", OP_LW,  3'b010, 1'b0, 1'b0, 1'b1, 3);
    resetCycles(2);
    applyStimulus("after_rst", OP_R,  3'b111, 1'b0, 1'b0, 1'b1, 99);

    for (int i = 0; i < 300; i++) begin
      pick = $urandom_range(0, 6);
      case (pick)
        0: rop = OP_LW;
        1: rop = OP_SW;
        2: rop = OP_R;
        3: rop = OP_I;
        4: rop = OP_JAL;
        5: rop = OP_BR;
        default: begin
          do rop = 7'($urandom_range(0, 127));
          while (rop == OP_LW || rop == OP_SW || rop == OP_R || rop == OP_I || rop == OP_JAL || rop == OP_BR);
        end
      endcase
      applyStimulus("random", rop, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0, 1'b1, 99);
      if ($urandom_range(0, 39) == 0) resetCycles(1);
    end

    for (int i = 0; i < 20 && expq.size() > 0; i++) @(posedge clk);
    if (expq.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: actual pending=%0d required pending=0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
